// File: rtl/axi_dma_desc_arbiter.sv
// Round-robin arbiter sharing one axi_dma descriptor channel among
// NUM_REQ requesters, with tag-based status routing and credit limits.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_desc_*                per-requester descriptor inputs (slice i = req i)
//   s_desc_ready            one-hot accept strobe (combinational, Idle only)
//   m_desc_*                registered descriptor to the DMA, tag = {tag, idx}
//   m_status_*              DMA completion (no backpressure)
//   s_status_*              registered completion routed to requester by idx
//   outstanding             per-requester in-flight descriptor count
//   err_bad_tag             sticky: status index outside 0..NUM_REQ-1
//   err_underflow           sticky: status for a requester with count 0
module axi_dma_desc_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int LEN_WIDTH       = 21,
    parameter int REQ_TAG_WIDTH   = 4,
    parameter int IDX_WIDTH       = $clog2(NUM_REQ),
    parameter int DMA_TAG_WIDTH   = REQ_TAG_WIDTH + IDX_WIDTH,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_desc_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     s_desc_len,
    input  logic [NUM_REQ*REQ_TAG_WIDTH-1:0] s_desc_tag,
    input  logic [NUM_REQ-1:0]               s_desc_valid,
    output logic [NUM_REQ-1:0]               s_desc_ready,
    output logic [ADDR_WIDTH-1:0]            m_desc_addr,
    output logic [LEN_WIDTH-1:0]             m_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]         m_desc_tag,
    output logic                             m_desc_valid,
    input  logic                             m_desc_ready,
    input  logic [DMA_TAG_WIDTH-1:0]         m_status_tag,
    input  logic [3:0]                       m_status_error,
    input  logic                             m_status_valid,
    output logic [REQ_TAG_WIDTH-1:0]         s_status_tag,
    output logic [3:0]                       s_status_error,
    output logic [NUM_REQ-1:0]               s_status_valid,
    output logic [NUM_REQ*CNT_WIDTH-1:0]     outstanding,
    output logic                             err_bad_tag,
    output logic                             err_underflow
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_WIDTH-1:0]       grant_q, grant_d;
    logic [IDX_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LEN_WIDTH-1:0]       len_q, len_d;
    logic [DMA_TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [CNT_WIDTH-1:0]       cnt_q [NUM_REQ];
    logic [CNT_WIDTH-1:0]       cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]         st_valid_q, st_valid_d;
    logic [REQ_TAG_WIDTH-1:0]   st_tag_q, st_tag_d;
    logic [3:0]                 st_err_q, st_err_d;
    logic                       bad_tag_q, bad_tag_d;
    logic                       underflow_q, underflow_d;

    logic [NUM_REQ-1:0]         elig;
    logic                       sel_found;
    int                         sel_i;
    logic                       issue_hs;
    logic [IDX_WIDTH-1:0]       st_idx;
    logic                       st_in_range;
    logic                       st_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = s_desc_valid[i] &&
                      (cnt_q[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    // Search wraps at NUM_REQ, not at 2^IDX_WIDTH.
    always_comb begin
        int c;
        c         = 0;
        sel_found = 1'b0;
        sel_i     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(rr_ptr_q) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!sel_found && elig[c]) begin
                sel_found = 1'b1;
                sel_i     = c;
            end
        end
    end

    always_comb begin
        int nxt;
        nxt          = 0;
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        addr_d       = addr_q;
        len_d        = len_q;
        tag_d        = tag_q;
        s_desc_ready = '0;
        m_desc_valid = 1'b0;
        issue_hs     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    s_desc_ready[sel_i] = 1'b1;
                    addr_d  = s_desc_addr[sel_i*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d   = s_desc_len[sel_i*LEN_WIDTH +: LEN_WIDTH];
                    tag_d   = {s_desc_tag[sel_i*REQ_TAG_WIDTH +: REQ_TAG_WIDTH],
                               IDX_WIDTH'(sel_i)};
                    grant_d = IDX_WIDTH'(sel_i);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_desc_valid = 1'b1;
                if (m_desc_ready) begin
                    issue_hs = 1'b1;
                    nxt      = int'(grant_q) + 1;
                    if (nxt >= NUM_REQ) nxt = 0;
                    rr_ptr_d = IDX_WIDTH'(nxt);
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    assign st_idx      = m_status_tag[IDX_WIDTH-1:0];
    assign st_in_range = int'(st_idx) < NUM_REQ;
    assign st_hit      = m_status_valid && st_in_range;

    always_comb begin
        st_tag_d    = st_tag_q;
        st_err_d    = st_err_q;
        bad_tag_d   = bad_tag_q | (m_status_valid & ~st_in_range);
        underflow_d = underflow_q;
        if (st_hit) begin
            st_tag_d = m_status_tag[DMA_TAG_WIDTH-1:IDX_WIDTH];
            st_err_d = m_status_error;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            logic inc;
            logic dec;
            inc           = issue_hs && (grant_q == IDX_WIDTH'(i));
            dec           = st_hit && (st_idx == IDX_WIDTH'(i));
            st_valid_d[i] = dec;
            cnt_d[i]      = cnt_q[i];
            // Same-cycle issue and completion cancel out.
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) underflow_d = 1'b1;
                else                cnt_d[i]    = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            tag_q       <= '0;
            st_valid_q  <= '0;
            st_tag_q    <= '0;
            st_err_q    <= '0;
            bad_tag_q   <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            tag_q       <= tag_d;
            st_valid_q  <= st_valid_d;
            st_tag_q    <= st_tag_d;
            st_err_q    <= st_err_d;
            bad_tag_q   <= bad_tag_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end

    assign m_desc_addr    = addr_q;
    assign m_desc_len     = len_q;
    assign m_desc_tag     = tag_q;
    assign s_status_valid = st_valid_q;
    assign s_status_tag   = st_tag_q;
    assign s_status_error = st_err_q;
    assign err_bad_tag    = bad_tag_q;
    assign err_underflow  = underflow_q;

endmodule

// File: tb/tb_axi_dma_desc_arbiter.sv
// Directed testbench for axi_dma_desc_arbiter (NUM_REQ=4 main instance,
// NUM_REQ=3 instance for wrap and bad-tag behaviour).
module tb_axi_dma_desc_arbiter;

    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int AW = 64;
    localparam int LW = 21;
    localparam int TW = 4;
    localparam int DW = 6;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N*AW-1:0] s_addr;
    logic [N*LW-1:0] s_len;
    logic [N*TW-1:0] s_tag;
    logic [N-1:0]    s_valid, s_ready;
    logic [AW-1:0]   m_addr;
    logic [LW-1:0]   m_len;
    logic [DW-1:0]   m_tag;
    logic            m_valid, m_ready;
    logic [DW-1:0]   ms_tag;
    logic [3:0]      ms_err;
    logic            ms_valid;
    logic [TW-1:0]   ss_tag;
    logic [3:0]      ss_err;
    logic [N-1:0]    ss_valid;
    logic [N*CW-1:0] outs;
    logic            bad_tag, underflow;

    logic [N3*AW-1:0] s3_addr;
    logic [N3*LW-1:0] s3_len;
    logic [N3*TW-1:0] s3_tag;
    logic [N3-1:0]    s3_valid, s3_ready;
    logic [AW-1:0]    m3_addr;
    logic [LW-1:0]    m3_len;
    logic [DW-1:0]    m3_tag;
    logic             m3_valid, m3_ready;
    logic [DW-1:0]    ms3_tag;
    logic [3:0]       ms3_err;
    logic             ms3_valid;
    logic [TW-1:0]    ss3_tag;
    logic [3:0]       ss3_err;
    logic [N3-1:0]    ss3_valid;
    logic [N3*CW-1:0] outs3;
    logic             bad_tag3, underflow3;

    axi_dma_desc_arbiter #(.NUM_REQ(N)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .s_desc_addr(s_addr), .s_desc_len(s_len), .s_desc_tag(s_tag),
        .s_desc_valid(s_valid), .s_desc_ready(s_ready),
        .m_desc_addr(m_addr), .m_desc_len(m_len), .m_desc_tag(m_tag),
        .m_desc_valid(m_valid), .m_desc_ready(m_ready),
        .m_status_tag(ms_tag), .m_status_error(ms_err),
        .m_status_valid(ms_valid),
        .s_status_tag(ss_tag), .s_status_error(ss_err),
        .s_status_valid(ss_valid),
        .outstanding(outs), .err_bad_tag(bad_tag),
        .err_underflow(underflow)
    );

    axi_dma_desc_arbiter #(.NUM_REQ(N3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .s_desc_addr(s3_addr), .s_desc_len(s3_len), .s_desc_tag(s3_tag),
        .s_desc_valid(s3_valid), .s_desc_ready(s3_ready),
        .m_desc_addr(m3_addr), .m_desc_len(m3_len), .m_desc_tag(m3_tag),
        .m_desc_valid(m3_valid), .m_desc_ready(m3_ready),
        .m_status_tag(ms3_tag), .m_status_error(ms3_err),
        .m_status_valid(ms3_valid),
        .s_status_tag(ss3_tag), .s_status_error(ss3_err),
        .s_status_valid(ss3_valid),
        .outstanding(outs3), .err_bad_tag(bad_tag3),
        .err_underflow(underflow3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int i, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input logic [TW-1:0] t);
        s_addr[i*AW +: AW] = a;
        s_len[i*LW +: LW]  = l;
        s_tag[i*TW +: TW]  = t;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_tag;
        int            exp_i;
        s_addr = '0; s_len = '0; s_tag = '0; s_valid = '0;
        m_ready = 1'b0; ms_tag = '0; ms_err = '0; ms_valid = 1'b0;
        s3_addr = '0; s3_len = '0; s3_tag = '0; s3_valid = '0;
        m3_ready = 1'b0; ms3_tag = '0; ms3_err = '0; ms3_valid = 1'b0;

        step();
        step();
        check("rst_mvalid", m_valid, 0);
        check("rst_mtag", m_tag, 0);
        check("rst_maddr", m_addr, 0);
        check("rst_sready", s_ready, 0);
        check("rst_outs", outs, 0);
        check("rst_ssvalid", ss_valid, 0);
        check("rst_flags", {bad_tag, underflow}, 0);
        rst = 1'b0;

        // single requester, DMA stalls for 3 cycles
        set_desc(2, 64'h1000, 21'd512, 4'd5);
        s_valid = 4'b0100;
        #1;
        check("t1_ready", s_ready, 4'b0100);
        step();
        s_valid = '0;
        check("t1_mvalid", m_valid, 1);
        check("t1_mtag", m_tag, 6'h16);
        check("t1_maddr", m_addr, 64'h1000);
        check("t1_mlen", m_len, 21'h200);
        check("t1_noready", s_ready, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("t1_hold_v", m_valid, 1);
            check("t1_hold_tag", m_tag, 6'h16);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("t1_drop", m_valid, 0);
        check("t1_outs2", outs[2*CW +: CW], 1);
        ms_tag = {4'd5, 2'd2};
        ms_valid = 1'b1;
        step();
        ms_valid = 1'b0;
        check("t1_st_v", ss_valid, 4'b0100);
        check("t1_st_tag", ss_tag, 5);
        check("t1_outs2_dec", outs[2*CW +: CW], 0);
        step();
        check("t1_st_pulse", ss_valid, 0);

        // fairness: all requesters valid, DMA always ready
        pulse_rst();
        for (int i = 0; i < N; i++)
            set_desc(i, 64'h100 * i, 21'd64, TW'(8 + i));
        s_valid = 4'b1111;
        m_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            exp_i   = g % N;
            exp_tag = {TW'(8 + exp_i), 2'(exp_i)};
            check("rr_ready", s_ready, 4'b0001 << exp_i);
            step();
            check("rr_mvalid", m_valid, 1);
            check("rr_mtag", m_tag, exp_tag);
            step();
        end
        s_valid = '0;
        m_ready = 1'b0;
        check("rr_outs", outs, 12'b001_001_010_010);

        // credit limit on requester 0
        pulse_rst();
        s_valid = 4'b0001;
        m_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            step();
            step();
        end
        check("cr_full", outs[0 +: CW], 4);
        s_valid = 4'b0011;
        #1;
        check("cr_skip", s_ready, 4'b0010);
        step();
        step();
        check("cr_skip_rr", s_ready, 4'b0010);
        step();
        step();
        s_valid = 4'b0001;
        #1;
        check("cr_block", s_ready, 0);
        ms_tag = {4'd3, 2'd0};
        ms_valid = 1'b1;
        step();
        ms_valid = 1'b0;
        check("cr_dec", outs[0 +: CW], 3);
        check("cr_st_v", ss_valid, 4'b0001);
        check("cr_regrant", s_ready, 4'b0001);
        step();
        check("cr_mtag", m_tag, 6'h20);
        step();
        s_valid = '0;
        m_ready = 1'b0;
        check("cr_refill", outs[0 +: CW], 4);

        // status routing to requester 3 (count 0 there)
        ms_tag = {4'd7, 2'd3};
        ms_err = 4'h2;
        ms_valid = 1'b1;
        step();
        ms_valid = 1'b0;
        ms_err = '0;
        check("st_valid", ss_valid, 4'b1000);
        check("st_tag", ss_tag, 7);
        check("st_err", ss_err, 2);
        check("st_uflow", underflow, 1);
        check("st_badtag", bad_tag, 0);
        check("st_outs3", outs[3*CW +: CW], 0);

        // simultaneous issue and completion on requester 1
        pulse_rst();
        check("sim_uflow_clr", underflow, 0);
        s_valid = 4'b0010;
        m_ready = 1'b1;
        step();
        step();
        check("sim_pre", outs[1*CW +: CW], 1);
        step();
        ms_tag = {4'd0, 2'd1};
        ms_valid = 1'b1;
        step();
        ms_valid = 1'b0;
        s_valid = '0;
        m_ready = 1'b0;
        check("sim_same", outs[1*CW +: CW], 1);
        check("sim_st_v", ss_valid, 4'b0010);
        check("sim_no_uflow", underflow, 0);
        ms_tag = {4'd0, 2'd0};
        ms_valid = 1'b1;
        step();
        ms_valid = 1'b0;
        check("uf_sat", outs[0 +: CW], 0);
        check("uf_flag", underflow, 1);

        // reset while a descriptor sits in Issue
        s_valid = 4'b0001;
        step();
        s_valid = '0;
        check("mr_pre", m_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_mvalid", m_valid, 0);
        check("mr_outs", outs, 0);
        check("mr_flags", {bad_tag, underflow}, 0);
        s_valid = 4'b1111;
        #1;
        check("mr_rr0", s_ready, 4'b0001);
        s_valid = '0;
        step();

        // NUM_REQ=3: wrap from 2 to 0 and out-of-range index
        s3_valid = 3'b100;
        m3_ready = 1'b1;
        #1;
        check("n3_ready2", s3_ready, 3'b100);
        step();
        step();
        s3_valid = 3'b101;
        #1;
        check("n3_wrap", s3_ready, 3'b001);
        s3_valid = '0;
        m3_ready = 1'b0;
        ms3_tag = {4'd1, 2'd3};
        ms3_valid = 1'b1;
        step();
        ms3_valid = 1'b0;
        check("n3_st_none", ss3_valid, 0);
        check("n3_badtag", bad_tag3, 1);
        check("n3_outs", outs3, 9'b001_000_000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
